// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I core: sequences ALU, memory
// port and writeback mux per instruction, stalls on mem_ready_i.
//
// Ports:
//   clk_i, reset_i        clock, async active-high reset
//   op_i/funct3_i/funct7b5_i  instruction fields
//   zero_i                ALU zero flag
//   mem_ready_i           memory completes current access this cycle
//   *_o                   datapath enables/selects (zero while reset_i=1)
//   instr_count_o         retired-instruction counter
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [6:0]       op_i,
  input  logic [2:0]       funct3_i,
  input  logic             funct7b5_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             adr_src_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             reg_write_o,
  output logic [1:0]       result_src_o,
  output logic [1:0]       alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_control_o,
  output logic [1:0]       imm_src_o,
  output logic             illegal_instr_o,
  output logic [CNT_W-1:0] instr_count_o
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic [2:0]       alu_fn;

  // State register and retirement counter
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op_i == OP_LW) ? S_MEMREAD
                                            : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready_i) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready_i) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Only completed instructions retire; illegal DECODE exit does not
  always_comb begin
    retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) ||
             (state_q == S_BEQ) ||
             ((state_q == S_MEMWRITE) && mem_ready_i);
    cnt_d  = cnt_q + CNT_W'(retire);
  end

  // ALU function decode (sub only for R-type with funct7b5)
  always_comb begin
    unique case (funct3_i)
      3'b000:  alu_fn = (op_i[5] && funct7b5_i) ? 3'b001 : 3'b000;
      3'b010:  alu_fn = 3'b101;
      3'b110:  alu_fn = 3'b011;
      3'b111:  alu_fn = 3'b010;
      default: alu_fn = 3'b000;
    endcase
  end

  // Output logic; reset gates everything so FETCH's mem_read
  // cannot leak while the core is held in reset
  always_comb begin
    pc_write_o      = 1'b0;
    adr_src_o       = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_write_o     = 1'b0;
    result_src_o    = 2'b00;
    alu_src_a_o     = 2'b00;
    alu_src_b_o     = 2'b00;
    alu_control_o   = 3'b000;
    illegal_instr_o = 1'b0;
    case (op_i)
      OP_SW:   imm_src_o = 2'b01;
      OP_BEQ:  imm_src_o = 2'b10;
      OP_JAL:  imm_src_o = 2'b11;
      default: imm_src_o = 2'b00;
    endcase
    unique case (state_q)
      S_FETCH: begin
        mem_read_o   = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        ir_write_o   = mem_ready_i;
        pc_write_o   = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        case (op_i)
          OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: ;
          default: illegal_instr_o = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
      end
      S_MEMREAD: begin
        adr_src_o  = 1'b1;
        mem_read_o = 1'b1;
      end
      S_MEMWB: begin
        result_src_o = 2'b01;
        reg_write_o  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_o   = 1'b1;
        mem_write_o = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_o   = 2'b10;
        alu_control_o = alu_fn;
      end
      S_EXECI: begin
        alu_src_a_o   = 2'b10;
        alu_src_b_o   = 2'b01;
        alu_control_o = alu_fn;
      end
      S_ALUWB: reg_write_o = 1'b1;
      S_BEQ: begin
        alu_src_a_o   = 2'b10;
        alu_control_o = 3'b001;
        pc_write_o    = zero_i;
      end
      S_JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_write_o  = 1'b1;
      end
      default: ;
    endcase
    if (reset_i) begin
      pc_write_o      = 1'b0;
      adr_src_o       = 1'b0;
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      ir_write_o      = 1'b0;
      reg_write_o     = 1'b0;
      result_src_o    = 2'b00;
      alu_src_a_o     = 2'b00;
      alu_src_b_o     = 2'b00;
      alu_control_o   = 3'b000;
      imm_src_o       = 2'b00;
      illegal_instr_o = 1'b0;
    end
  end

  assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed per-cycle vectors,
// expected outputs queued by the driver and checked by a negedge monitor.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  op = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        funct7b5 = 1'b0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        pc_write, adr_src, mem_read, mem_write;
  logic        ir_write, reg_write, illegal;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_control;
  logic [31:0] instr_count;

  multicycle_controller #(.CNT_W(32)) dut (
    .clk_i(clk), .reset_i(reset), .op_i(op), .funct3_i(funct3),
    .funct7b5_i(funct7b5), .zero_i(zero), .mem_ready_i(mem_ready),
    .pc_write_o(pc_write), .adr_src_o(adr_src),
    .mem_read_o(mem_read), .mem_write_o(mem_write),
    .ir_write_o(ir_write), .reg_write_o(reg_write),
    .result_src_o(result_src), .alu_src_a_o(alu_src_a),
    .alu_src_b_o(alu_src_b), .alu_control_o(alu_control),
    .imm_src_o(imm_src), .illegal_instr_o(illegal),
    .instr_count_o(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [19:0] v;
    logic [31:0] c;
  } exp_t;

  exp_t q[$];
  int   pass_cnt = 0;
  int   total    = 0;
  logic [19:0] got;

  assign got = {pc_write, adr_src, mem_read, mem_write, ir_write,
                reg_write, result_src, alu_src_a, alu_src_b,
                alu_control, imm_src, illegal};

  // {pcw,adr,mr,mw,irw,rw,rs,a,b,alu,imm,ill}
  function automatic logic [19:0] e(
    int pcw, int adr, int mr, int mw, int irw, int rw,
    int rs, int a, int b, int alu, int imm, int ill);
    logic [19:0] r;
    r = {pcw[0], adr[0], mr[0], mw[0], irw[0], rw[0],
         rs[1:0], a[1:0], b[1:0], alu[2:0], imm[1:0], ill[0]};
    return r;
  endfunction

  task automatic cyc(input string nm, input logic rst,
                     input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic rdy,
                     input logic [19:0] ev, input int c);
    exp_t it;
    @(posedge clk);
    #1;
    reset = rst; op = o; funct3 = f3; funct7b5 = f7;
    zero = z; mem_ready = rdy;
    it.nm = nm; it.v = ev; it.c = c;
    q.push_back(it);
  endtask

  // Monitor: every sampled cycle pops and compares
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t it;
      it = q.pop_front();
      total++;
      if (got !== it.v || instr_count !== it.c)
        $display("FAIL %s: got out=%05h cnt=%0d exp out=%05h cnt=%0d",
                 it.nm, got, instr_count, it.v, it.c);
      else
        pass_cnt++;
    end
  end

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  initial begin
    // Reset held with mem_ready high
    cyc("rst0", 1, LW, 0, 0, 0, 1, e(0,0,0,0,0,0,0,0,0,0,0,0), 0);
    cyc("rst1", 1, LW, 0, 0, 0, 1, e(0,0,0,0,0,0,0,0,0,0,0,0), 0);
    // lw with 3 wait cycles in MEMREAD
    cyc("lw_fetch", 0, LW, 0, 0, 0, 1, e(1,0,1,0,1,0,2,0,2,0,0,0), 0);
    cyc("lw_dec",   0, LW, 0, 0, 0, 1, e(0,0,0,0,0,0,0,1,1,0,0,0), 0);
    cyc("lw_madr",  0, LW, 0, 0, 0, 0, e(0,0,0,0,0,0,0,2,1,0,0,0), 0);
    cyc("lw_rd_w1", 0, LW, 0, 0, 0, 0, e(0,1,1,0,0,0,0,0,0,0,0,0), 0);
    cyc("lw_rd_w2", 0, LW, 0, 0, 0, 0, e(0,1,1,0,0,0,0,0,0,0,0,0), 0);
    cyc("lw_rd_w3", 0, LW, 0, 0, 0, 0, e(0,1,1,0,0,0,0,0,0,0,0,0), 0);
    cyc("lw_rd",    0, LW, 0, 0, 0, 1, e(0,1,1,0,0,0,0,0,0,0,0,0), 0);
    cyc("lw_wb",    0, LW, 0, 0, 0, 1, e(0,0,0,0,0,1,1,0,0,0,0,0), 0);
    // R-type sub, with one fetch stall first
    cyc("sub_fstall", 0, RT, 0, 1, 0, 0, e(0,0,1,0,0,0,2,0,2,0,0,0), 1);
    cyc("sub_fetch",  0, RT, 0, 1, 0, 1, e(1,0,1,0,1,0,2,0,2,0,0,0), 1);
    cyc("sub_dec",    0, RT, 0, 1, 0, 1, e(0,0,0,0,0,0,0,1,1,0,0,0), 1);
    cyc("sub_exec",   0, RT, 0, 1, 0, 1, e(0,0,0,0,0,0,0,2,0,1,0,0), 1);
    cyc("sub_wb",     0, RT, 0, 1, 0, 1, e(0,0,0,0,0,1,0,0,0,0,0,0), 1);
    // R-type slt
    cyc("slt_fetch", 0, RT, 2, 0, 0, 1, e(1,0,1,0,1,0,2,0,2,0,0,0), 2);
    cyc("slt_dec",   0, RT, 2, 0, 0, 1, e(0,0,0,0,0,0,0,1,1,0,0,0), 2);
    cyc("slt_exec",  0, RT, 2, 0, 0, 1, e(0,0,0,0,0,0,0,2,0,5,0,0), 2);
    cyc("slt_wb",    0, RT, 2, 0, 0, 1, e(0,0,0,0,0,1,0,0,0,0,0,0), 2);
    // addi with funct7b5 set: op[5]=0 keeps it add
    cyc("addi_fetch", 0, IT, 0, 1, 0, 1, e(1,0,1,0,1,0,2,0,2,0,0,0), 3);
    cyc("addi_dec",   0, IT, 0, 1, 0, 1, e(0,0,0,0,0,0,0,1,1,0,0,0), 3);
    cyc("addi_exec",  0, IT, 0, 1, 0, 1, e(0,0,0,0,0,0,0,2,1,0,0,0), 3);
    cyc("addi_wb",    0, IT, 0, 1, 0, 1, e(0,0,0,0,0,1,0,0,0,0,0,0), 3);
    // andi then ori
    cyc("andi_fetch", 0, IT, 7, 0, 0, 1, e(1,0,1,0,1,0,2,0,2,0,0,0), 4);
    cyc("andi_dec",   0, IT, 7, 0, 0, 1, e(0,0,0,0,0,0,0,1,1,0,0,0), 4);
    cyc("andi_exec",  0, IT, 7, 0, 0, 1, e(0,0,0,0,0,0,0,2,1,2,0,0), 4);
    cyc("andi_wb",    0, IT, 7, 0, 0, 1, e(0,0,0,0,0,1,0,0,0,0,0,0), 4);
    cyc("ori_fetch",  0, IT, 6, 0, 0, 1, e(1,0,1,0,1,0,2,0,2,0,0,0), 5);
    cyc("ori_dec",    0, IT, 6, 0, 0, 1, e(0,0,0,0,0,0,0,1,1,0,0,0), 5);
    cyc("ori_exec",   0, IT, 6, 0, 0, 1, e(0,0,0,0,0,0,0,2,1,3,0,0), 5);
    cyc("ori_wb",     0, IT, 6, 0, 0, 1, e(0,0,0,0,0,1,0,0,0,0,0,0), 5);
    // beq taken / not taken
    cyc("beqt_fetch", 0, BQ, 0, 0, 1, 1, e(1,0,1,0,1,0,2,0,2,0,2,0), 6);
    cyc("beqt_dec",   0, BQ, 0, 0, 1, 1, e(0,0,0,0,0,0,0,1,1,0,2,0), 6);
    cyc("beqt_beq",   0, BQ, 0, 0, 1, 1, e(1,0,0,0,0,0,0,2,0,1,2,0), 6);
    cyc("beqn_fetch", 0, BQ, 0, 0, 0, 1, e(1,0,1,0,1,0,2,0,2,0,2,0), 7);
    cyc("beqn_dec",   0, BQ, 0, 0, 0, 1, e(0,0,0,0,0,0,0,1,1,0,2,0), 7);
    cyc("beqn_beq",   0, BQ, 0, 0, 0, 1, e(0,0,0,0,0,0,0,2,0,1,2,0), 7);
    // jal
    cyc("jal_fetch", 0, JL, 0, 0, 0, 1, e(1,0,1,0,1,0,2,0,2,0,3,0), 8);
    cyc("jal_dec",   0, JL, 0, 0, 0, 1, e(0,0,0,0,0,0,0,1,1,0,3,0), 8);
    cyc("jal_jal",   0, JL, 0, 0, 0, 1, e(1,0,0,0,0,0,0,1,2,0,3,0), 8);
    cyc("jal_wb",    0, JL, 0, 0, 0, 1, e(0,0,0,0,0,1,0,0,0,0,3,0), 8);
    // illegal opcode: pulse in DECODE, back to FETCH, no retire
    cyc("ill_fetch", 0, BAD, 0, 0, 0, 1, e(1,0,1,0,1,0,2,0,2,0,0,0), 9);
    cyc("ill_dec",   0, BAD, 0, 0, 0, 1, e(0,0,0,0,0,0,0,1,1,0,0,1), 9);
    // sw completes immediately; mem_ready low in MEMADR is ignored
    cyc("sw_fetch", 0, SW, 0, 0, 0, 1, e(1,0,1,0,1,0,2,0,2,0,1,0), 9);
    cyc("sw_dec",   0, SW, 0, 0, 0, 1, e(0,0,0,0,0,0,0,1,1,0,1,0), 9);
    cyc("sw_madr",  0, SW, 0, 0, 0, 0, e(0,0,0,0,0,0,0,2,1,0,1,0), 9);
    cyc("sw_wr",    0, SW, 0, 0, 0, 1, e(0,1,0,1,0,0,0,0,0,0,1,0), 9);
    // sw stalled, then reset mid-cycle while in MEMWRITE
    cyc("sw2_fetch", 0, SW, 0, 0, 0, 1, e(1,0,1,0,1,0,2,0,2,0,1,0), 10);
    cyc("sw2_dec",   0, SW, 0, 0, 0, 1, e(0,0,0,0,0,0,0,1,1,0,1,0), 10);
    cyc("sw2_madr",  0, SW, 0, 0, 0, 1, e(0,0,0,0,0,0,0,2,1,0,1,0), 10);
    cyc("sw2_wr_w",  0, SW, 0, 0, 0, 0, e(0,1,0,1,0,0,0,0,0,0,1,0), 10);
    cyc("sw2_arst",  1, SW, 0, 0, 0, 0, e(0,0,0,0,0,0,0,0,0,0,0,0), 0);
    cyc("post_fetch", 0, SW, 0, 0, 0, 1, e(1,0,1,0,1,0,2,0,2,0,1,0), 0);
    cyc("post_dec",   0, SW, 0, 0, 0, 1, e(0,0,0,0,0,0,0,1,1,0,1,0), 0);
    // Drain the scoreboard, bounded
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending exp 0", q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences the shared ALU, unified memory port and writeback result mux across several cycles per instruction.
- Supports lw, sw, R-type ALU, I-type ALU, beq and jal.
- Stalls on a memory-ready handshake and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- op  input  7  instruction opcode, instr[6:0]
- funct3  input  3  instr[14:12]
- funct7b5  input  1  instr[30]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- pc_write  output  1  PC register load enable
- adr_src  output  1  memory address select: 0=PC, 1=ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register and OldPC load enable
- reg_write  output  1  register file write enable
- result_src  output  2  writeback mux select: 00=ALUOut, 01=read data, 10=live ALU result
- alu_src_a  output  2  ALU A select: 00=PC, 01=OldPC, 10=rs1 register
- alu_src_b  output  2  ALU B select: 00=rs2 register, 01=immediate, 10=constant 4
- alu_control  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  output  2  immediate format: 00 I, 01 S, 10 B, 11 J
- illegal_instr  output  1  one-cycle pulse on an unsupported opcode
- instr_count  output  CNT_W  number of retired instructions

Behaviour:
- Reset is asynchronous. While reset=1: state=FETCH, instr_count=0, and every output is forced to 0, including mem_read.
- Opcodes: lw 0000011, sw 0100011, R-type 0110011, I-type 0010011, beq 1100011, jal 1101111.
- Moore FSM. Any output not listed for a state is 0; mux selects default to 00.
- FETCH:
  - mem_read=1, adr_src=0, a=00, b=10, op=add, result_src=10.
  - While mem_ready=0: hold in FETCH with no enables asserted.
  - When mem_ready=1: ir_write=1 and pc_write=1 in that cycle; next state DECODE.
- DECODE:
  - a=01, b=01, add. This computes the branch target into ALUOut.
  - Next state by op: lw/sw->MEMADR, R->EXECR, I->EXECI, beq->BEQ, jal->JAL.
  - Any other op: illegal_instr=1 for this cycle, next state FETCH, count not incremented.
- MEMADR: a=10, b=01, add. Next state MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adr_src=1, mem_read=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1. Next state FETCH.
- MEMWRITE: adr_src=1, mem_write=1. Hold until mem_ready=1, then go to FETCH.
- EXECR: a=10, b=00, funct-decoded ALU op. Next state ALUWB.
- EXECI: a=10, b=01, funct-decoded ALU op. Next state ALUWB.
- ALUWB: result_src=00, reg_write=1. Next state FETCH.
- BEQ: a=10, b=00, sub, result_src=00, pc_write=zero. Next state FETCH.
- JAL:
  - a=01, b=10, add (OldPC+4).
  - result_src=00, so the PC loads the jump target from ALUOut; pc_write=1.
  - Next state ALUWB, which writes the return address OldPC+4.
- Funct decode, used in EXECR/EXECI only:
  - funct3 000: sub when op[5]=1 and funct7b5=1, otherwise add.
  - funct3 010: slt. funct3 110: or. funct3 111: and. Any other funct3: add.
- imm_src is combinational from op in every state: sw->01, beq->10, jal->11, all others->00.
- Retirement counter:
  - instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWRITE (on mem_ready), ALUWB or BEQ.
  - It does not increment on the DECODE-illegal return to FETCH.
  - It wraps modulo 2^CNT_W.
- mem_ready is ignored in states that issue no memory request.
- A mid-instruction reset abandons the instruction immediately: no pending write or PC update completes, and the FSM restarts in FETCH after release.

Test Plan:
- Assert reset, hold mem_ready=1 -> all outputs 0 and instr_count=0. Release reset -> first cycle shows mem_read=1, ir_write=1, pc_write=1, result_src=10.
- lw with mem_ready low for 3 cycles in MEMREAD -> mem_read held 3 extra cycles. Sequence FETCH, DECODE, MEMADR, MEMREAD×4, MEMWB. reg_write=1 with result_src=01 exactly once; instr_count=1.
- R-type sub (funct3=000, funct7b5=1) -> alu_control=001 in EXECR, then ALUWB with reg_write=1. R-type slt -> 101. Total 4 cycles with mem_ready=1.
- beq with zero=1 -> pc_write=1 in BEQ. With zero=0 -> pc_write=0. Both return to FETCH and increment instr_count.
- jal -> JAL cycle pc_write=1, a=01, b=10. Then ALUWB reg_write=1. imm_src=11 throughout.
- op=1111111 -> illegal_instr pulses 1 cycle in DECODE, next state FETCH, instr_count unchanged. Reset asserted during MEMWRITE -> mem_write drops asynchronously, state returns to FETCH.
